// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, BOOT/RUN/HALT sequencing, IF/ID pipeline
// register with stall/flush/redirect handling, and a delivered-instruction counter.
module fetch_stage #(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     StallF,
  input  logic                     StallD,
  input  logic                     FlushD,
  input  logic                     PCSrcE,
  input  logic [ADDRESS_WIDTH-1:0] PCTargetE,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic [ADDRESS_WIDTH-1:0] imem_rdata,
  output logic [ADDRESS_WIDTH-1:0] InstrD,
  output logic [ADDRESS_WIDTH-1:0] PCD,
  output logic [ADDRESS_WIDTH-1:0] PCPlus4D,
  output logic                     ValidD,
  output logic                     Halted,
  output logic [31:0]              FetchCount
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  // addi x0,x0,0 -- what decode sees when IF/ID holds no real instruction
  localparam logic [ADDRESS_WIDTH-1:0] NOP = ADDRESS_WIDTH'(32'h0000_0013);

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] pcf_q, pcf_d, pcf_plus4;
  logic [ADDRESS_WIDTH-1:0] instr_q, pcd_q, pcplus4_q;
  logic                     valid_q;
  logic [31:0]              fetch_count_q;
  logic                     halt_detect, load_valid, load_bubble;

  // NOTE: every signal assigned in this always_comb gets a default first, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    pcf_plus4   = pcf_q + ADDRESS_WIDTH'(4);
    halt_detect = (state_q == RUN) && (imem_rdata == '0) && !StallF && !PCSrcE;
    state_d     = state_q;
    pcf_d       = pcf_q;
    load_valid  = 1'b0;
    load_bubble = 1'b0;

    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (halt_detect) state_d = HALT;
      HALT:    if (PCSrcE) state_d = RUN;
      default: state_d = BOOT;
    endcase

    // A redirect wins over everything; a detected zero word parks the PC on itself.
    if (PCSrcE)
      pcf_d = PCTargetE;
    else if (state_q == RUN && !StallF && !halt_detect)
      pcf_d = pcf_plus4;

    if (FlushD)
      load_bubble = 1'b1;
    else if (!StallD) begin
      if (state_q != RUN || PCSrcE || halt_detect)
        load_bubble = 1'b1;
      else
        load_valid = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= BOOT;
      pcf_q         <= RESET_PC;
      instr_q       <= NOP;
      pcd_q         <= '0;
      pcplus4_q     <= '0;
      valid_q       <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q <= state_d;
      pcf_q   <= pcf_d;
      if (load_valid) begin
        instr_q       <= imem_rdata;
        pcd_q         <= pcf_q;
        pcplus4_q     <= pcf_plus4;
        valid_q       <= 1'b1;
        fetch_count_q <= fetch_count_q + 32'd1;
      end else if (load_bubble) begin
        instr_q   <= NOP;
        pcd_q     <= '0;
        pcplus4_q <= '0;
        valid_q   <= 1'b0;
      end
    end
  end

  assign imem_addr  = pcf_q;
  assign InstrD     = instr_q;
  assign PCD        = pcd_q;
  assign PCPlus4D   = pcplus4_q;
  assign ValidD     = valid_q;
  assign Halted     = (state_q == HALT);
  assign FetchCount = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: boot, sequential fetch, stalls, redirects,
// halt on zero word, counter wrap and reset out of HALT.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0, PCSrcE = 1'b0;
  logic [31:0] PCTargetE = '0;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] InstrD, PCD, PCPlus4D, FetchCount;
  logic        ValidD, Halted;

  int vectors = 0;
  int miscompares = 0;

  fetch_stage #(.ADDRESS_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .ValidD(ValidD), .Halted(Halted), .FetchCount(FetchCount)
  );

  always #5 clk = ~clk;

  // Instruction ROM: zero word at 0x10 acts as the halt marker.
  always_comb begin
    case (imem_addr)
      32'h00: imem_rdata = 32'h0050_0093;
      32'h04: imem_rdata = 32'h00A0_0113;
      32'h08: imem_rdata = 32'h0020_81B3;
      32'h0C: imem_rdata = 32'h0011_8213;
      32'h10: imem_rdata = 32'h0000_0000;
      32'h20: imem_rdata = 32'h0010_0293;
      32'h40: imem_rdata = 32'h0020_0313;
      32'h44: imem_rdata = 32'h0030_0393;
      default: imem_rdata = 32'h0000_0013;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state, with noise on the other inputs
    StallF = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h80;
    step(); step();
    check("rst_addr",   imem_addr,  32'h0);
    check("rst_instr",  InstrD,     32'h13);
    check("rst_valid",  {31'b0, ValidD}, 32'h0);
    check("rst_count",  FetchCount, 32'h0);
    check("rst_halted", {31'b0, Halted}, 32'h0);
    StallF = 1'b0; PCSrcE = 1'b0;

    // BOOT cycle: bubble, PC held
    rst = 1'b0;
    step();
    check("boot_valid", {31'b0, ValidD}, 32'h0);
    check("boot_addr",  imem_addr, 32'h0);

    // Sequential fetch from 0 and 4
    step();
    check("f0_pcd",    PCD,      32'h0);
    check("f0_instr",  InstrD,   32'h0050_0093);
    check("f0_plus4",  PCPlus4D, 32'h4);
    check("f0_valid",  {31'b0, ValidD}, 32'h1);
    step();
    check("f4_pcd",    PCD,        32'h4);
    check("f4_count",  FetchCount, 32'h2);
    check("f4_addr",   imem_addr,  32'h8);

    // Two-cycle stall at PCF=8
    StallF = 1'b1; StallD = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("stall_addr",  imem_addr,  32'h8);
      check("stall_pcd",   PCD,        32'h4);
      check("stall_instr", InstrD,     32'h00A0_0113);
      check("stall_count", FetchCount, 32'h2);
    end
    StallF = 1'b0; StallD = 1'b0;
    step();
    check("f8_pcd",   PCD,        32'h8);
    check("f8_instr", InstrD,     32'h0020_81B3);
    check("f8_count", FetchCount, 32'h3);
    step();
    check("fc_pcd",   PCD,        32'hC);
    check("fc_addr",  imem_addr,  32'h10);

    // Zero word at 0x10 -> HALT, PC held, bubble
    step();
    check("halt_flag",  {31'b0, Halted}, 32'h1);
    check("halt_addr",  imem_addr,  32'h10);
    check("halt_valid", {31'b0, ValidD}, 32'h0);
    check("halt_count", FetchCount, 32'h4);
    step();
    check("halt_hold",  {31'b0, Halted}, 32'h1);
    check("halt_addr2", imem_addr,  32'h10);

    // Redirect out of HALT to 0x20
    PCSrcE = 1'b1; PCTargetE = 32'h20;
    step();
    check("unhalt_flag",  {31'b0, Halted}, 32'h0);
    check("unhalt_addr",  imem_addr, 32'h20);
    check("unhalt_valid", {31'b0, ValidD}, 32'h0);
    PCSrcE = 1'b0;
    step();
    check("f20_pcd",   PCD,        32'h20);
    check("f20_instr", InstrD,     32'h0010_0293);
    check("f20_count", FetchCount, 32'h5);

    // Redirect overrides StallF, with FlushD
    PCSrcE = 1'b1; PCTargetE = 32'h40; StallF = 1'b1; FlushD = 1'b1;
    step();
    check("redir_addr",  imem_addr, 32'h40);
    check("redir_valid", {31'b0, ValidD}, 32'h0);
    check("redir_count", FetchCount, 32'h5);
    PCSrcE = 1'b0; StallF = 1'b0; FlushD = 1'b0;
    step();
    check("f40_pcd",   PCD,        32'h40);
    check("f40_plus4", PCPlus4D,   32'h44);
    check("f40_count", FetchCount, 32'h6);

    // Counter wrap
    force dut.fetch_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.fetch_count_q;
    check("preload", FetchCount, 32'hFFFF_FFFF);
    step();
    check("wrap_count", FetchCount, 32'h0);
    check("wrap_pcd",   PCD,        32'h44);

    // Halt again, then reset from HALT with other inputs active
    PCSrcE = 1'b1; PCTargetE = 32'h10;
    step();
    PCSrcE = 1'b0;
    step();
    check("halt2_flag", {31'b0, Halted}, 32'h1);
    rst = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h80; StallF = 1'b1; StallD = 1'b1;
    step();
    check("hrst_addr",   imem_addr,  32'h0);
    check("hrst_halted", {31'b0, Halted}, 32'h0);
    check("hrst_valid",  {31'b0, ValidD}, 32'h0);
    check("hrst_count",  FetchCount, 32'h0);
    rst = 1'b0; PCSrcE = 1'b0; StallF = 1'b0; StallD = 1'b0;
    step();
    check("reboot_valid", {31'b0, ValidD}, 32'h0);
    step();
    check("reboot_pcd",   PCD,        32'h0);
    check("reboot_count", FetchCount, 32'h1);

    // PC+4 wraps modulo 2^32
    PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
    step();
    PCSrcE = 1'b0;
    check("top_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    check("top_pcd",   PCD,       32'hFFFF_FFFC);
    check("top_plus4", PCPlus4D,  32'h0);
    check("top_next",  imem_addr, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
